// File: rtl/motor_ramp_driver_pkg.sv
// motor_drv_pkg
// Shared constants for the motor ramp driver: default parameter values and
// the FSM state encodings used by motor_ramp_driver.
// No ports (package).
package motor_drv_pkg;

  // Default configuration: 15 ramp steps of 16 duty counts, 4 clocks per step.
  localparam int CNT_W_DEF       = 8;
  localparam int MAX_DUTY_DEF    = 240;
  localparam int DUTY_STEP_DEF   = 16;
  localparam int STEP_CYCLES_DEF = 4;

  // FSM state encodings, kept as plain constants for legacy tool compatibility.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ARMED     = 3'd1;
  localparam logic [2:0] ST_RAMP_UP   = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd4;
  localparam logic [2:0] ST_FAULT     = 3'd5;

endpackage

// File: rtl/motor_ramp_driver_pwm_gen.sv
// pwm_gen
// Free-running PWM counter with a registered compare. For a duty value D the
// output is high for exactly D cycles of every 2^CNT_W-cycle period.
// Ports:
//   clk    - system clock, rising edge
//   resetn - asynchronous active-low reset
//   duty   - duty value (CNT_W bits)
//   pwm    - registered PWM output
module pwm_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [CNT_W-1:0] duty,
  output logic             pwm
);

  logic [CNT_W-1:0] cnt_q;
  logic             pwm_q;

  // Counter wraps naturally at 2^CNT_W; the compare is registered so the
  // power stage never sees combinational glitches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      pwm_q <= (cnt_q < duty);
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/motor_ramp_driver.sv
// motor_ramp_driver
// Turns the supervisor's arm pulse (f) and run request (g) into a soft-start /
// soft-stop PWM motor drive. The duty ramps in DUTY_STEP increments every
// STEP_CYCLES clocks and is then held at MAX_DUTY. A run request without a
// prior arm pulse locks the block into a sticky fault until reset.
// Ports:
//   clk      - system clock, rising edge
//   resetn   - asynchronous active-low reset
//   f        - arm pulse from supervisor FSM
//   g        - run request from supervisor FSM
//   pwm      - registered motor drive
//   duty     - current duty value
//   at_speed - high while running at full duty
//   armed    - high in every state except IDLE and FAULT
//   fault    - sticky protocol fault
module motor_ramp_driver
  import motor_drv_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MAX_DUTY    = MAX_DUTY_DEF,
  parameter int DUTY_STEP   = DUTY_STEP_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             f,
  input  logic             g,
  output logic             pwm,
  output logic [CNT_W-1:0] duty,
  output logic             at_speed,
  output logic             armed,
  output logic             fault
);

  localparam int               TMR_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W:0]   STEP_EXT = (CNT_W + 1)'(DUTY_STEP);
  localparam logic [CNT_W:0]   MAX_EXT  = (CNT_W + 1)'(MAX_DUTY);
  localparam logic [CNT_W-1:0] MAX_VAL  = CNT_W'(MAX_DUTY);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic             stepFire;
  logic [CNT_W:0]   sumExt, diffExt;
  logic [CNT_W-1:0] dutyUp, dutyDown;

  // Ramp arithmetic is done one bit wider than the duty so that overflow and
  // borrow are visible and can be saturated instead of wrapping.
  always_comb begin
    stepFire = (tmr_q == TMR_LAST);
    sumExt   = {1'b0, duty_q} + STEP_EXT;
    diffExt  = {1'b0, duty_q} - STEP_EXT;
    dutyUp   = (sumExt > MAX_EXT) ? MAX_VAL : sumExt[CNT_W-1:0];
    dutyDown = diffExt[CNT_W] ? '0 : diffExt[CNT_W-1:0];
  end

  // Next-state logic. Every transition into a ramp state clears the step
  // timer, so the first step always lands STEP_CYCLES edges after entry.
  // Dropping g in RAMP_UP wins over a simultaneous step and holds the duty.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (f) begin
          state_d = ST_ARMED;
        end else if (g) begin
          state_d = ST_FAULT;
          duty_d  = '0;
        end
      end
      ST_ARMED: begin
        if (g) begin
          state_d = ST_RAMP_UP;
          tmr_d   = '0;
        end
      end
      ST_RAMP_UP: begin
        if (!g) begin
          state_d = ST_RAMP_DOWN;
          tmr_d   = '0;
        end else if (stepFire) begin
          duty_d = dutyUp;
          tmr_d  = '0;
          if (dutyUp == MAX_VAL) state_d = ST_RUN;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_RUN: begin
        duty_d = MAX_VAL;
        if (!g) begin
          state_d = ST_RAMP_DOWN;
          tmr_d   = '0;
        end
      end
      ST_RAMP_DOWN: begin
        if (g) begin
          state_d = ST_RAMP_UP;
          tmr_d   = '0;
        end else if (stepFire) begin
          duty_d = dutyDown;
          tmr_d  = '0;
          if (dutyDown == '0) state_d = ST_ARMED;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_FAULT: begin
        duty_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        duty_d  = '0;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tmr_q   <= tmr_d;
    end
  end

  // Status flags decode straight from the state register so they drop the
  // instant reset is asserted.
  assign at_speed = (state_q == ST_RUN);
  assign armed    = (state_q != ST_IDLE) && (state_q != ST_FAULT);
  assign fault    = (state_q == ST_FAULT);
  assign duty     = duty_q;

  pwm_gen #(
    .CNT_W(CNT_W)
  ) uPwmGen (
    .clk   (clk),
    .resetn(resetn),
    .duty  (duty_q),
    .pwm   (pwm)
  );

endmodule
